// File: rtl/reshape_input_if.sv
// Stream bundle for reshape_input: IN_WIDTH-word input beats in, one TOTAL-word
// assembled vector out, each side with its own valid/ready handshake.
interface reshape_input_if #(
    parameter int TOTAL    = 40,
    parameter int IN_WIDTH = 8
);
    logic [IN_WIDTH-1:0][15:0] in;
    logic                      s_valid;
    logic                      s_ready;
    logic                      s_last;
    logic [TOTAL-1:0][15:0]    out;
    logic                      m_valid;
    logic                      m_ready;
    logic                      err;

    modport master (
        output in, s_valid, s_last, m_ready,
        input  s_ready, out, m_valid, err
    );

    modport slave (
        input  in, s_valid, s_last, m_ready,
        output s_ready, out, m_valid, err
    );
endinterface

// File: rtl/reshape_input.sv
// Deserializing packer: collects IN_LENGTH beats of IN_WIDTH 16-bit words into one
// TOTAL-word vector and holds it on a registered output until downstream takes it.
module reshape_input #(
    parameter int TOTAL    = 40,
    parameter int IN_WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    reshape_input_if.slave bus
);
    localparam int IN_LENGTH      = TOTAL / IN_WIDTH;
    localparam int CW             = $clog2(IN_LENGTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(IN_LENGTH - 1);

    typedef logic [IN_WIDTH-1:0][15:0] beat_t;

    generate
        if (TOTAL % IN_WIDTH != 0) begin : g_bad_width
            $error("reshape_input: IN_WIDTH must divide TOTAL");
        end
    endgenerate

    beat_t                  banks_q [IN_LENGTH];
    beat_t                  banks_d [IN_LENGTH];
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [TOTAL-1:0][15:0] out_q, out_d;
    logic                   m_valid_q, m_valid_d;
    logic                   err_q, err_d;

    logic at_last;
    logic s_ready;
    logic accept;

    // Only the completing beat has to wait for the output register to free up.
    assign at_last = (cnt_q == LAST);
    assign s_ready = ~at_last | ~m_valid_q | bus.m_ready;
    assign accept  = bus.s_valid & s_ready;

    always_comb begin
        banks_d   = banks_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        m_valid_d = m_valid_q;
        err_d     = 1'b0;

        if (m_valid_q && bus.m_ready) begin
            m_valid_d = 1'b0;
        end

        if (accept) begin
            if (at_last) begin
                // Last row bypasses the banks so the vector appears one edge after its final beat.
                for (int k = 0; k < IN_LENGTH - 1; k++) begin
                    out_d[k*IN_WIDTH +: IN_WIDTH] = banks_q[k];
                end
                out_d[(IN_LENGTH-1)*IN_WIDTH +: IN_WIDTH] = bus.in;
                m_valid_d = 1'b1;
                cnt_d     = '0;
                err_d     = ~bus.s_last;
            end else if (bus.s_last) begin
                cnt_d = '0;
                err_d = 1'b1;
            end else begin
                for (int k = 0; k < IN_LENGTH; k++) begin
                    if (cnt_q == CW'(k)) begin
                        banks_d[k] = bus.in;
                    end
                end
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            banks_q   <= '{default: '0};
            cnt_q     <= '0;
            out_q     <= '0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            banks_q   <= banks_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.out     = out_q;
    assign bus.m_valid = m_valid_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_reshape_input.sv
// Randomized and directed checks of reshape_input against a word-queue reference model.
module tb_reshape_input;
    localparam int TOTAL     = 40;
    localparam int IN_WIDTH  = 8;
    localparam int IN_LENGTH = TOTAL / IN_WIDTH;
    localparam int VW        = TOTAL * 16;

    typedef logic [IN_WIDTH-1:0][15:0] beat_t;

    logic clk;
    logic reset;

    reshape_input_if #(.TOTAL(TOTAL), .IN_WIDTH(IN_WIDTH)) bus ();

    reshape_input #(.TOTAL(TOTAL), .IN_WIDTH(IN_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pending words of the current vector, and the expected output side.
    logic [15:0]   part [$];
    logic [VW-1:0] m_out;
    bit            m_mv;
    bit            m_err;
    bit            acc_last;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int base);
        beat_t b;
        for (int j = 0; j < IN_WIDTH; j++) b[j] = 16'(base + j);
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        for (int j = 0; j < IN_WIDTH; j++) b[j] = 16'($urandom);
        return b;
    endfunction

    task automatic model_reset();
        part.delete();
        m_out = '0;
        m_mv  = 1'b0;
        m_err = 1'b0;
    endtask

    // One clock cycle; called at a falling edge, returns at the next falling edge.
    task automatic cycle(input bit v, input bit last, input bit mr, input beat_t b);
        bit rdy, acc, done, nerr;
        bus.in      = b;
        bus.s_valid = v;
        bus.s_last  = last;
        bus.m_ready = mr;
        #1;
        rdy = (part.size() != (IN_LENGTH - 1) * IN_WIDTH) || !m_mv || mr;
        chk("s_ready", VW'(bus.s_ready), VW'(rdy));
        acc      = v && rdy;
        acc_last = acc;
        done     = 1'b0;
        nerr     = 1'b0;
        if (acc) begin
            for (int j = 0; j < IN_WIDTH; j++) part.push_back(b[j]);
            if (part.size() == TOTAL) begin
                for (int i = 0; i < TOTAL; i++) m_out[i*16 +: 16] = part[i];
                done = 1'b1;
                nerr = !last;
                part.delete();
            end else if (last) begin
                part.delete();
                nerr = 1'b1;
            end
        end
        if (done) m_mv = 1'b1;
        else if (m_mv && mr) m_mv = 1'b0;
        m_err = nerr;
        @(posedge clk);
        #1;
        chk("m_valid", VW'(bus.m_valid), VW'(m_mv));
        chk("err", VW'(bus.err), VW'(m_err));
        chk("out", bus.out, m_out);
        @(negedge clk);
    endtask

    task automatic send(input beat_t b, input bit last, input bit mr);
        int tries = 0;
        do begin
            cycle(1'b1, last, mr, b);
            tries++;
        end while (!acc_last && tries < 20);
        if (!acc_last) chk("send_timeout", VW'(0), VW'(1));
    endtask

    task automatic idle(input int n, input bit mr);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, mr, '0);
    endtask

    task automatic send_vec(input int base, input bit mr, input bit use_last);
        for (int k = 0; k < IN_LENGTH; k++)
            send(mk_beat(base + k * IN_WIDTH), use_last && (k == IN_LENGTH - 1), mr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] ramp;
        reset       = 1'b1;
        bus.in      = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_m_valid", VW'(bus.m_valid), VW'(0));
        chk("rst_err", VW'(bus.err), VW'(0));
        chk("rst_out", bus.out, '0);
        reset = 1'b0;

        // Basic assembly: out[i] = i
        send_vec(0, 1'b1, 1'b1);
        for (int i = 0; i < TOTAL; i++) ramp[i*16 +: 16] = 16'(i);
        chk("basic_out", bus.out, ramp);
        chk("basic_mv", VW'(bus.m_valid), VW'(1));
        idle(2, 1'b1);

        // Backpressure: A held, 4 beats of B accepted, 5th stalls until m_ready
        send_vec(1000, 1'b0, 1'b1);
        for (int k = 0; k < IN_LENGTH - 1; k++) send(mk_beat(2000 + k * IN_WIDTH), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, mk_beat(2000 + (IN_LENGTH - 1) * IN_WIDTH));
        cycle(1'b1, 1'b1, 1'b1, mk_beat(2000 + (IN_LENGTH - 1) * IN_WIDTH));
        chk("bp_accept", VW'(acc_last), VW'(1));
        idle(2, 1'b1);

        // Streaming: three vectors back to back
        for (int v = 0; v < 3; v++) send_vec(3000 + v * 100, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Early last on beat 2, then a clean vector
        for (int k = 0; k < 3; k++) send(mk_beat(4000 + k * IN_WIDTH), k == 2, 1'b1);
        send_vec(5000, 1'b1, 1'b1);
        idle(1, 1'b1);

        // Missing last
        send_vec(6000, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit v, mr, last;
            v  = $urandom_range(0, 3) != 0;
            mr = $urandom_range(0, 2) != 0;
            if (part.size() == (IN_LENGTH - 1) * IN_WIDTH) last = $urandom_range(0, 9) != 0;
            else last = $urandom_range(0, 19) == 0;
            cycle(v, last, mr, rnd_beat());
        end
        idle(3, 1'b1);

        // Reset mid-vector while a vector is held
        send_vec(7000, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) send(mk_beat(8000 + k * IN_WIDTH), 1'b0, 1'b0);
        chk("pre_rst_mv", VW'(bus.m_valid), VW'(1));
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_mv", VW'(bus.m_valid), VW'(0));
        chk("mid_rst_err", VW'(bus.err), VW'(0));
        chk("mid_rst_out", bus.out, '0);
        @(negedge clk);
        reset = 1'b0;
        send_vec(9000, 1'b1, 1'b1);
        idle(2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
